ultrasonic_trigger: RTL and testbench

Initiator side of the ultrasonic ranging interface.
- Drives the sensor trigger pulse and watches the returned echo line.
- Emits a clean `measuring` gate that drives the `enable` input of the pulse-width counter.
- Enforces echo timeout and minimum repetition period; supports single-shot and free-running modes.
- Sits between the robot control FSM (start/auto) and the sensor pins.

---
 rtl/ultrasonic_pkg.sv | 22 ++
 rtl/echo_sync.sv | 72 +++++++
 rtl/ultrasonic_trigger.sv | 131 +++++++++++++
 tb/tb_ultrasonic_trigger.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ultrasonic_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ultrasonic_pkg
// Brief   : State encodings and 50 MHz timing defaults for the ultrasonic
//           ranging initiator.
// Rev     : 1.0
// ============================================================================
package ultrasonic_pkg;

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_TRIG      = 3'd1;
    localparam logic [2:0] c_WAIT_RISE = 3'd2;
    localparam logic [2:0] c_ECHO_HIGH = 3'd3;
    localparam logic [2:0] c_HOLDOFF   = 3'd4;

    localparam int unsigned c_DEF_TRIG_CYCLES    = 500;
    localparam int unsigned c_DEF_TIMEOUT_CYCLES = 1_500_000;
    localparam int unsigned c_DEF_PERIOD_CYCLES  = 3_000_000;
    localparam int unsigned c_DEF_CNT_W          = 22;

endpackage
`default_nettype wire

// File: rtl/echo_sync.sv
`default_nettype none
// ============================================================================
// Module  : echo_sync
// Brief   : Two-flop synchronizer with registered rise/fall strobes. Defining
//           ECHO_GLITCH_FILTER_EN inserts a 3-sample majority filter.
// Rev     : 1.0
// ============================================================================
module echo_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_dly;
    logic r_rise;
    logic r_fall;
    logic w_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= async_in;
            r_sync <= r_meta;
        end
    end

`ifdef ECHO_GLITCH_FILTER_EN
    logic r_h1;
    logic r_h2;
    logic r_filt;

    // Majority of the current and two previous samples kills 1-cycle pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h1   <= 1'b0;
            r_h2   <= 1'b0;
            r_filt <= 1'b0;
        end else begin
            r_h1   <= r_sync;
            r_h2   <= r_h1;
            r_filt <= (r_sync & r_h1) | (r_sync & r_h2) | (r_h1 & r_h2);
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dly  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_dly  <= w_level;
            r_rise <= w_level & ~r_dly;
            r_fall <= ~w_level & r_dly;
        end
    end

    assign rise = r_rise;
    assign fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/ultrasonic_trigger.sv
`default_nettype none
// ============================================================================
// Module  : ultrasonic_trigger
// Brief   : Ultrasonic sensor initiator: trigger pulse, echo gate, timeout and
//           repetition holdoff. Optional echo filter: ECHO_GLITCH_FILTER_EN.
// Rev     : 1.0
// ============================================================================
module ultrasonic_trigger
    import ultrasonic_pkg::*;
#(
    parameter int unsigned TRIG_CYCLES    = c_DEF_TRIG_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = c_DEF_TIMEOUT_CYCLES,
    parameter int unsigned PERIOD_CYCLES  = c_DEF_PERIOD_CYCLES,
    parameter int unsigned CNT_W          = c_DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic auto_en,
    input  logic echo,
    output logic trig,
    output logic measuring,
    output logic busy,
    output logic cycle_done,
    output logic timeout
);

    localparam logic [CNT_W-1:0] c_TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_PER_LAST  = CNT_W'(PERIOD_CYCLES - 1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_elapsed;
    logic             r_trig;
    logic             r_measuring;
    logic             r_busy;
    logic             r_cycle_done;
    logic             r_timeout;
    logic             w_rise;
    logic             w_fall;

    echo_sync u_echo_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (echo),
        .rise     (w_rise),
        .fall     (w_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_elapsed    <= '0;
            r_trig       <= 1'b0;
            r_measuring  <= 1'b0;
            r_busy       <= 1'b0;
            r_cycle_done <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_cycle_done <= 1'b0;
            r_timeout    <= 1'b0;
            if (r_elapsed != '1) begin
                r_elapsed <= r_elapsed + 1'b1;
            end

            case (r_state)
                c_IDLE: begin
                    if (start || auto_en) begin
                        r_state   <= c_TRIG;
                        r_elapsed <= '0;
                        r_trig    <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                c_TRIG: begin
                    if (r_elapsed == c_TRIG_LAST) begin
                        r_state <= c_WAIT_RISE;
                        r_trig  <= 1'b0;
                    end
                end
                c_WAIT_RISE: begin
                    if (r_elapsed == c_TO_LAST) begin
                        r_state   <= c_HOLDOFF;
                        r_timeout <= 1'b1;
                    end else if (w_rise) begin
                        r_state     <= c_ECHO_HIGH;
                        r_measuring <= 1'b1;
                    end
                end
                c_ECHO_HIGH: begin
                    // Timeout is checked first so it wins over a coincident fall.
                    if (r_elapsed == c_TO_LAST) begin
                        r_state     <= c_HOLDOFF;
                        r_measuring <= 1'b0;
                        r_timeout   <= 1'b1;
                    end else if (w_fall) begin
                        r_state      <= c_HOLDOFF;
                        r_measuring  <= 1'b0;
                        r_cycle_done <= 1'b1;
                    end
                end
                c_HOLDOFF: begin
                    if (r_elapsed == c_PER_LAST) begin
                        if (auto_en) begin
                            r_state   <= c_TRIG;
                            r_elapsed <= '0;
                            r_trig    <= 1'b1;
                        end else begin
                            r_state <= c_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= c_IDLE;
                    r_trig      <= 1'b0;
                    r_measuring <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign trig       = r_trig;
    assign measuring  = r_measuring;
    assign busy       = r_busy;
    assign cycle_done = r_cycle_done;
    assign timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ultrasonic_trigger.sv
`default_nettype none
// ============================================================================
// Module  : tb_ultrasonic_trigger
// Brief   : Directed and random stimulus against a transaction-level model of
//           the ranging cycle (trigger, echo window, timeout, holdoff).
// Rev     : 1.0
// ============================================================================
module tb_ultrasonic_trigger;

    localparam int TRIG    = 4;
    localparam int TMO     = 40;
    localparam int PERIOD  = 60;
    localparam int N       = 1600;
    localparam int NMAX    = N + 128;
    localparam int LAT     = 3;  // pin sample to rise/fall strobe visible to the FSM

    logic clk = 1'b0;
    logic rst_n, start, auto_en, echo;
    logic trig, measuring, busy, cycle_done, timeout;

    ultrasonic_trigger #(
        .TRIG_CYCLES    (TRIG),
        .TIMEOUT_CYCLES (TMO),
        .PERIOD_CYCLES  (PERIOD),
        .CNT_W          (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .auto_en    (auto_en),
        .echo       (echo),
        .trig       (trig),
        .measuring  (measuring),
        .busy       (busy),
        .cycle_done (cycle_done),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    bit s_start [N];
    bit s_auto  [N];
    bit s_echo  [N];
    bit e_trig  [NMAX];
    bit e_meas  [NMAX];
    bit e_busy  [NMAX];
    bit e_done  [NMAX];
    bit e_to    [NMAX];

    function automatic bit pin(int i);
        if (i < 0 || i >= N) return 1'b0;
        return s_echo[i];
    endfunction

    task automatic check(string tag, logic [4:0] obs, logic [4:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b (trig,meas,busy,done,tmo)", tag, obs, exp);
        end
    endtask

    // One ranging cycle whose trigger request is sampled at cycle t0.
    task automatic model_cycle(int t0);
        int v;
        int vf;
        v  = -1;
        vf = -1;
        for (int c = t0 + 1; c <= t0 + PERIOD; c++) e_busy[c] = 1'b1;
        for (int c = t0 + 1; c <= t0 + TRIG; c++)   e_trig[c] = 1'b1;
        for (int c = t0 + TRIG + 1; c <= t0 + TMO - 1 && v < 0; c++)
            if (pin(c - LAT) && !pin(c - LAT - 1)) v = c;
        if (v >= 0) begin
            for (int c = v + 1; c <= t0 + TMO - 1 && vf < 0; c++)
                if (!pin(c - LAT) && pin(c - LAT - 1)) vf = c;
            if (vf >= 0) begin
                for (int c = v + 1; c <= vf; c++) e_meas[c] = 1'b1;
                e_done[vf + 1] = 1'b1;
            end else begin
                for (int c = v + 1; c <= t0 + TMO; c++) e_meas[c] = 1'b1;
                e_to[t0 + TMO + 1] = 1'b1;
            end
        end else begin
            e_to[t0 + TMO + 1] = 1'b1;
        end
    endtask

    task automatic build_model();
        int idle_from;
        int t0;
        int nd;
        idle_from = 0;
        while (idle_from < N) begin
            t0 = -1;
            for (int c = idle_from; c < N && t0 < 0; c++)
                if (s_start[c] || s_auto[c]) t0 = c;
            if (t0 < 0) break;
            forever begin
                model_cycle(t0);
                nd = t0 + PERIOD;
                if (nd < N && s_auto[nd]) t0 = nd;
                else break;
            end
            idle_from = nd + 1;
        end
    endtask

    initial begin
        int c;
        int lvl;
        int run;
        int guard;
        string tag;

        for (int i = 0; i < N; i++) begin
            s_start[i] = 0; s_auto[i] = 0; s_echo[i] = 0;
        end
        for (int i = 0; i < NMAX; i++) begin
            e_trig[i] = 0; e_meas[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_to[i] = 0;
        end

        // Single shot, echo 10 cycles wide
        s_start[5] = 1;
        for (int i = 15; i <= 24; i++) s_echo[i] = 1;
        // Echo never arrives
        s_start[70] = 1;
        // Stale echo held through the trigger, then a clean echo next cycle
        for (int i = 135; i <= 190; i++) s_echo[i] = 1;
        s_start[140] = 1;
        s_start[205] = 1;
        for (int i = 215; i <= 229; i++) s_echo[i] = 1;
        // Free-running for three periods with ignored start pulses
        for (int i = 270; i <= 449; i++) s_auto[i] = 1;
        s_start[300] = 1; s_start[350] = 1; s_start[420] = 1;
        for (int i = 280; i <= 290; i++) s_echo[i] = 1;
        for (int i = 345; i <= 352; i++) s_echo[i] = 1;
        for (int i = 400; i <= 402; i++) s_echo[i] = 1;
        // Fall coincides with timeout: timeout wins
        s_start[460] = 1;
        for (int i = 470; i <= 496; i++) s_echo[i] = 1;
        // Rise at the last accepted elapsed value
        s_start[525] = 1;
        for (int i = 561; i <= 570; i++) s_echo[i] = 1;
        // Random region
        lvl = 0;
        c = 590;
        while (c < N - 100) begin
            run = $urandom_range(1, 25);
            for (int i = c; i < c + run && i < N - 100; i++) s_echo[i] = lvl[0];
            lvl = ~lvl;
            c += run;
        end
        c = 590;
        while (c < N - 100) begin
            run = $urandom_range(50, 200);
            lvl = ($urandom_range(0, 2) == 0) ? 1 : 0;
            for (int i = c; i < c + run && i < N - 100; i++) s_auto[i] = lvl[0];
            c += run;
        end
        for (int i = 590; i < N - 100; i++) s_start[i] = ($urandom_range(0, 19) == 0);

        build_model();

        rst_n = 0; start = 0; auto_en = 0; echo = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", {trig, measuring, busy, cycle_done, timeout}, 5'b0);
        rst_n = 1;

        for (int i = 0; i < N; i++) begin
            start   = s_start[i];
            auto_en = s_auto[i];
            echo    = s_echo[i];
            @(negedge clk);
            $sformat(tag, "cycle%0d", i);
            check(tag, {trig, measuring, busy, cycle_done, timeout},
                  {e_trig[i], e_meas[i], e_busy[i], e_done[i], e_to[i]});
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of a measurement
        start = 0; auto_en = 0; echo = 0;
        guard = 0;
        while (busy && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        check("idle_before_reset", {4'b0, busy}, 5'b0);
        start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (8) @(posedge clk);
        #1;
        echo = 1;
        guard = 0;
        while (!measuring && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        check("enter_echo_high", {trig, measuring, busy, cycle_done, timeout}, 5'b01100);
        #2;
        rst_n = 0;
        #1;
        check("async_reset", {trig, measuring, busy, cycle_done, timeout}, 5'b0);
        @(posedge clk); #3;
        rst_n = 1;
        for (int i = 0; i < 80; i++) begin
            echo = (i % 7) < 3;
            @(negedge clk);
            $sformat(tag, "post_reset%0d", i);
            check(tag, {trig, measuring, busy, cycle_done, timeout}, 5'b0);
            @(posedge clk); #1;
        end
        echo = 0;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        check("restart", {trig, measuring, busy, cycle_done, timeout}, 5'b10100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
